draw_arbiter: RTL

- Shares the single VGA adapter write port (x, y, colour, plot) between three box-drawing requesters: the board-reset sweep, the player-one drawer and the player-two drawer.
- Each granted request is expanded into a BOX_SIZE x BOX_SIZE raster of pixel writes, one pixel per clock, and then acknowledged.
- The block sits between the game-logic requesters and the vga_adapter instance.

---
 rtl/draw_pkg.sv | 16 +
 rtl/box_pixel_counter.sv | 41 ++++
 rtl/draw_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/draw_pkg.sv
// Shared constants for the box-drawing arbiter: requester indices, bus widths, FSM encoding.
package draw_pkg;
    localparam int NUM_REQ = 3;
    localparam logic [1:0] REQ_RESET = 2'd0;
    localparam logic [1:0] REQ_P1    = 2'd1;
    localparam logic [1:0] REQ_P2    = 2'd2;
    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/box_pixel_counter.sv
// Raster dx/dy counter for a BOX_SIZE square; dx_nxt/dy_nxt give the following pixel, last flags the final one.
// Clear has priority over enable; no backpressure, advances one pixel per enabled clock.
module box_pixel_counter #(
    parameter int BOX_SIZE = 3
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] dx_nxt,
    output logic [3:0] dy_nxt,
    output logic       last
);
    localparam logic [3:0] MAX = 4'(BOX_SIZE - 1);

    logic [3:0] dx;
    logic [3:0] dy;

    always_comb begin
        dx_nxt = dx + 4'd1;
        dy_nxt = dy;
        if (dx == MAX) begin
            dx_nxt = 4'd0;
            dy_nxt = dy + 4'd1;
        end
        last = (dx == MAX) && (dy == MAX);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dx <= 4'd0;
            dy <= 4'd0;
        end else if (clr) begin
            dx <= 4'd0;
            dy <= 4'd0;
        end else if (en) begin
            dx <= dx_nxt;
            dy <= dy_nxt;
        end
    end
endmodule

// File: rtl/draw_arbiter.sv
// Grants the VGA write port to one of three box requesters and rasters BOX_SIZE^2 pixels, one per clock.
// Box takes BOX_SIZE^2+2 cycles (pixels, ack, return to idle); requests are only sampled in IDLE.
module draw_arbiter import draw_pkg::*; #(
    parameter int BOX_SIZE = 3,
    parameter int X_W      = draw_pkg::X_W,
    parameter int Y_W      = draw_pkg::Y_W,
    parameter int C_W      = draw_pkg::C_W
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*X_W-1:0] req_x,
    input  logic [NUM_REQ*Y_W-1:0] req_y,
    input  logic [NUM_REQ*C_W-1:0] req_colour,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   busy,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [C_W-1:0]         vga_colour,
    output logic                   vga_plot
);
    state_t         state_q;
    state_t         state_d;
    logic [1:0]     ptr;
    logic [1:0]     grant;
    logic [1:0]     win;
    logic [X_W-1:0] lx;
    logic [Y_W-1:0] ly;
    logic [X_W-1:0] wx;
    logic [Y_W-1:0] wy;
    logic [C_W-1:0] wc;
    logic [3:0]     dx_nxt;
    logic [3:0]     dy_nxt;
    logic           last;

    box_pixel_counter #(.BOX_SIZE(BOX_SIZE)) u_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clr    (state_q == IDLE),
        .en     (state_q == DRAW),
        .dx_nxt (dx_nxt),
        .dy_nxt (dy_nxt),
        .last   (last)
    );

    // Reset sweep always wins; players alternate only when both are asking.
    always_comb begin
        win = REQ_P2;
        if (req[REQ_RESET])
            win = REQ_RESET;
        else if (req[REQ_P1] && req[REQ_P2])
            win = ptr;
        else if (req[REQ_P1])
            win = REQ_P1;

        wx = req_x[REQ_P2*X_W +: X_W];
        wy = req_y[REQ_P2*Y_W +: Y_W];
        wc = req_colour[REQ_P2*C_W +: C_W];
        case (win)
            REQ_RESET: begin
                wx = req_x[REQ_RESET*X_W +: X_W];
                wy = req_y[REQ_RESET*Y_W +: Y_W];
                wc = req_colour[REQ_RESET*C_W +: C_W];
            end
            REQ_P1: begin
                wx = req_x[REQ_P1*X_W +: X_W];
                wy = req_y[REQ_P1*Y_W +: Y_W];
                wc = req_colour[REQ_P1*C_W +: C_W];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = DRAW;
            DRAW:    if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            ptr        <= REQ_P1;
            grant      <= REQ_RESET;
            lx         <= '0;
            ly         <= '0;
            ack        <= '0;
            busy       <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (|req) begin
                    grant      <= win;
                    lx         <= wx;
                    ly         <= wy;
                    vga_x      <= wx;
                    vga_y      <= wy;
                    vga_colour <= wc;
                    vga_plot   <= 1'b1;
                    busy       <= 1'b1;
                    if (win != REQ_RESET)
                        ptr <= (win == REQ_P1) ? REQ_P2 : REQ_P1;
                end
                DRAW: begin
                    if (last) begin
                        vga_plot   <= 1'b0;
                        ack[grant] <= 1'b1;
                    end else begin
                        vga_x <= lx + X_W'(dx_nxt);
                        vga_y <= ly + Y_W'(dy_nxt);
                    end
                end
                DONE: begin
                    ack  <= '0;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
